alu32: RTL and testbench
========================

Name: alu32

Overview:
- 32-bit combinational integer ALU for the RV32I-style core datapath.
- Performs AND/OR/XOR, logical and arithmetic shifts, add/sub and signed/unsigned set-less-than, selected by a 4-bit control code from alu_types.
- Produces result, overflow, zero and equal flags combinationally.
- A small clocked side path holds a registered copy of the result and a sticky overflow flag for debug/exception use.

Parameters:
- N, 32, datapath width; only 32 is supported, used as a constant.

Ports:
- clk  in  1  clock for the registered side path only
- rst  in  1  asynchronous active-high reset
- a  in  N  operand A
- b  in  N  operand B; also the shift amount
- control  in  4 (alu_control_t)  operation select
- result  out  N  combinational result of the selected operation
- overflow  out  1  signed overflow of ADD/SUB, combinational
- zero  out  1  high when result == 0, combinational
- equal  out  1  high when a == b, combinational, independent of control
- result_q  out  N  result registered on rising clk
- overflow_sticky  out  1  set on any rising clk edge where overflow=1; held until rst

Behaviour:
- Control encoding:
  - INVALID=0000, AND=0001, OR=0010, XOR=0011
  - SLL=0101, SRL=0110, SRA=0111
  - ADD=1000, SUB=1100, SLT=1101, SLTU=1111
  - Any other code behaves as INVALID.
- Outputs result, overflow, zero and equal are purely combinational: no latency, stable within 1 ns of an input change, and unaffected by clk/rst.
- AND/OR/XOR: bitwise.
- Shifts:
  - Shift amount is b[4:0] when b[31:5]==0.
  - If any bit of b[31:5] is set: SLL and SRL give 0; SRA gives 32 copies of a[31].
  - SRA fills with a[31]; SRL fills with 0.
- ADD: a+b mod 2^32. SUB: a-b mod 2^32, implemented as a + ~b + 1 through the shared adder.
- Overflow:
  - ADD: 1 iff a[31]==b[31] and result[31]!=a[31].
  - SUB: 1 iff a[31]!=b[31] and result[31]!=a[31].
  - 0 for all other ops, including SLT/SLTU and INVALID.
- SLT:
  - result = {31'b0, signed(a) < signed(b)}.
  - Derived from the subtractor as diff[31] XOR sub_overflow, so it is correct at 0x80000000/0x7FFFFFFF extremes.
- SLTU:
  - result = {31'b0, unsigned(a) < unsigned(b)}.
  - Derived from the inverted carry-out of a + ~b + 1.
- INVALID: result = 0, so zero = 1.
- zero = (result == 0) for every op; equal = (a == b) for every op.
- Registered side path:
  - On rst high (async): result_q = 0, overflow_sticky = 0, immediately.
  - On rising clk with rst low: result_q <= result; overflow_sticky <= overflow_sticky | overflow.
  - Reset asserted mid-operation clears both regardless of clk; the combinational outputs are unaffected.
- Outputs must never be X/Z for known inputs. The bench compares with !== against a behavioural model (alu_behavioural, same port list minus clk/rst/result_q/overflow_sticky) across all 11 control codes.
- Structure:
  - Gate-level or structural adder/shifter modules are acceptable.
  - The behavioural model uses SystemVerilog operators with the identical rules above.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 -> result=0x80000000, overflow=1, zero=0, equal=0. Then a=0xFFFFFFFF, b=1 -> result=0, overflow=0, zero=1.
- SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1. SUB a=b=0x12345678 -> result=0, zero=1, equal=1, overflow=0.
- SLT/SLTU a=0xFFFFFFFF, b=1:
  - SLT -> 1; SLTU -> 0.
  - SLT a=0x80000000, b=0x7FFFFFFF -> 1; SLTU same operands -> 0.
  - overflow=0 throughout.
- Shifts with a=0x80000001:
  - SLL b=4 -> 0x00000010; SRL b=4 -> 0x08000000; SRA b=4 -> 0xF8000000.
  - SRA b=32 -> 0xFFFFFFFF; SLL b=0x100 -> 0.
- Logic and INVALID:
  - a=0xF0F0F0F0, b=0xFF00FF00: AND -> 0xF000F000, OR -> 0xFFF0FFF0, XOR -> 0x0FF00FF0.
  - control=0000 -> result=0, zero=1.
- Clocked path:
  - Assert rst -> result_q=0, overflow_sticky=0 without a clock edge.
  - Release rst; ADD 0x7FFFFFFF+1 and clock once -> result_q=0x80000000, overflow_sticky=1.
  - Switch to AND and clock -> overflow_sticky stays 1 until rst.
- Exhaustive cross: all 11 controls × a 24-value corner set (0, 1, 0xFFFFFFFF, 0x80000000, 0x7FFFFFFF, walking ones, …) × 25 random pairs -> zero mismatches versus the behavioural model on all four outputs.

Source files
------------

// File: rtl/alu32_if.sv
// Operand/result bundle for alu32. The master drives operands and control;
// the slave (the ALU) returns combinational results plus the registered side path.
interface alu32_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic [31:0] result;
  logic        overflow;
  logic        zero;
  logic        equal;
  logic [31:0] result_q;
  logic        overflow_sticky;

  modport master (
    output a, b, control,
    input  result, overflow, zero, equal, result_q, overflow_sticky
  );

  modport slave (
    input  a, b, control,
    output result, overflow, zero, equal, result_q, overflow_sticky
  );
endinterface

// File: rtl/alu32.sv
// 32-bit combinational integer ALU with a shared add/sub adder, a shifter, and a
// small clocked side path that holds a copy of the result and a sticky overflow.
module alu32 (
  input  logic    clk,
  input  logic    rst,
  alu32_if.slave  bus
);
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_SUB  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  logic [31:0] a, b;
  logic [3:0]  ctrl;
  assign a    = bus.a;
  assign b    = bus.b;
  assign ctrl = bus.control;

  // SUB and both compares run through the same a + ~b + 1 path.
  logic        do_sub;
  logic [31:0] b_eff;
  logic [32:0] sum_full;
  logic [31:0] sum;
  logic        carry_out;
  logic        add_ovf;

  assign do_sub    = (ctrl == OP_SUB) || (ctrl == OP_SLT) || (ctrl == OP_SLTU);
  assign b_eff     = do_sub ? ~b : b;
  assign sum_full  = {1'b0, a} + {1'b0, b_eff} + {32'd0, do_sub};
  assign sum       = sum_full[31:0];
  assign carry_out = sum_full[32];
  assign add_ovf   = (a[31] == b_eff[31]) && (sum[31] != a[31]);

  // Out-of-range shift amounts saturate instead of wrapping on b[4:0].
  logic        shamt_big;
  logic [4:0]  shamt;
  logic [31:0] sll_res, srl_res, sra_res;

  assign shamt_big = |b[31:5];
  assign shamt     = b[4:0];
  assign sll_res   = shamt_big ? 32'd0 : (a << shamt);
  assign srl_res   = shamt_big ? 32'd0 : (a >> shamt);
  assign sra_res   = shamt_big ? {32{a[31]}} : 32'($signed(a) >>> shamt);

  logic [31:0] result;
  logic        overflow;

  always_comb begin
    result   = 32'd0;
    overflow = 1'b0;
    case (ctrl)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = sll_res;
      OP_SRL:  result = srl_res;
      OP_SRA:  result = sra_res;
      OP_ADD:  begin result = sum; overflow = add_ovf; end
      OP_SUB:  begin result = sum; overflow = add_ovf; end
      OP_SLT:  result = {31'd0, sum[31] ^ add_ovf};
      OP_SLTU: result = {31'd0, ~carry_out};
      default: result = 32'd0;
    endcase
  end

  assign bus.result   = result;
  assign bus.overflow = overflow;
  assign bus.zero     = (result == 32'd0);
  assign bus.equal    = (a == b);

  logic [31:0] result_q, result_d;
  logic        sticky_q, sticky_d;

  always_comb begin
    result_d = result;
    sticky_d = sticky_q | overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= 32'd0;
      sticky_q <= 1'b0;
    end else begin
      result_q <= result_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.result_q        = result_q;
  assign bus.overflow_sticky = sticky_q;
endmodule

// File: tb/tb_alu32.sv
// Self-checking bench for alu32: directed vector table, clocked-path sequence,
// and a corner/random cross against a plain-arithmetic reference model.
module tb_alu32;
  logic clk;
  logic rst;
  alu32_if bus_if ();

  alu32 dut (.clk(clk), .rst(rst), .bus(bus_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        eq;
  } alu_out_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
    logic        zero;
    logic        eq;
  } vec_t;

  // Reference: straight from the arithmetic rules, using 64-bit signed math.
  function automatic alu_out_t ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    alu_out_t o;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    o.res = 32'd0;
    o.ovf = 1'b0;
    case (c)
      4'd1:  o.res = a & b;
      4'd2:  o.res = a | b;
      4'd3:  o.res = a ^ b;
      4'd5:  o.res = (b >= 32'd32) ? 32'd0 : (a << b[4:0]);
      4'd6:  o.res = (b >= 32'd32) ? 32'd0 : (a >> b[4:0]);
      4'd7:  o.res = (b >= 32'd32) ? {32{a[31]}} : 32'($signed(a) >>> b[4:0]);
      4'd8:  begin s = sa + sb; o.res = s[31:0]; o.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd12: begin s = sa - sb; o.res = s[31:0]; o.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd13: o.res = {31'd0, (sa < sb)};
      4'd15: o.res = {31'd0, (a < b)};
      default: o.res = 32'd0;
    endcase
    o.zero = (o.res == 32'd0);
    o.eq   = (a == b);
    return o;
  endfunction

  task automatic apply(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    bus_if.control = c;
    bus_if.a       = a;
    bus_if.b       = b;
    #1;
  endtask

  task automatic cmp_comb(input string name, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input alu_out_t e);
    n_checks++;
    if (bus_if.result !== e.res || bus_if.overflow !== e.ovf ||
        bus_if.zero !== e.zero || bus_if.equal !== e.eq) begin
      n_fail++;
      $display("FAIL %s ctrl=%h a=%h b=%h got res=%h ovf=%b z=%b eq=%b want res=%h ovf=%b z=%b eq=%b",
               name, c, a, b, bus_if.result, bus_if.overflow, bus_if.zero, bus_if.equal,
               e.res, e.ovf, e.zero, e.eq);
    end
  endtask

  task automatic cmp_reg(input string name, input logic [31:0] rq, input logic st);
    n_checks++;
    if (bus_if.result_q !== rq || bus_if.overflow_sticky !== st) begin
      n_fail++;
      $display("FAIL %s got result_q=%h sticky=%b want result_q=%h sticky=%b",
               name, bus_if.result_q, bus_if.overflow_sticky, rq, st);
    end
  endtask

  task automatic check_model(input string name, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b);
    apply(c, a, b);
    cmp_comb(name, c, a, b, ref_alu(c, a, b));
  endtask

  vec_t        vecs[$];
  logic [31:0] corners[24];
  logic [3:0]  ctrls[11];

  initial begin
    alu_out_t e;
    ctrls = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'hC, 4'hD, 4'hF};

    vecs.push_back('{4'h8, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'h8, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'hC, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'hC, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{4'hC, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{4'hD, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'hF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'hD, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'hF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'hD, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'h5, 32'h80000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h6, 32'h80000001, 32'h00000004, 32'h08000000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h7, 32'h80000001, 32'h00000004, 32'hF8000000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h7, 32'h80000001, 32'h00000020, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h5, 32'h80000001, 32'h00000100, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'h6, 32'h80000001, 32'h00000020, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'h7, 32'h7FFFFFFF, 32'h00000040, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{4'h4, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1});

    corners[0]  = 32'h00000000; corners[1]  = 32'h00000001; corners[2]  = 32'h00000002;
    corners[3]  = 32'hFFFFFFFF; corners[4]  = 32'h80000000; corners[5]  = 32'h7FFFFFFF;
    corners[6]  = 32'hFFFFFFFE; corners[7]  = 32'h80000001; corners[8]  = 32'h0000001F;
    corners[9]  = 32'h00000020; corners[10] = 32'h00000021; corners[11] = 32'h55555555;
    for (int k = 0; k < 12; k++) corners[12 + k] = 32'h1 << (2 * k + 3);

    // Reset state, no clock edge needed.
    rst = 1'b1;
    apply(4'h0, 32'h0, 32'h0);
    #2;
    cmp_reg("reset_state", 32'h0, 1'b0);

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].ctrl, vecs[i].a, vecs[i].b);
      e.res = vecs[i].res; e.ovf = vecs[i].ovf; e.zero = vecs[i].zero; e.eq = vecs[i].eq;
      cmp_comb($sformatf("vec%0d", i), vecs[i].ctrl, vecs[i].a, vecs[i].b, e);
    end

    // Clocked side path.
    @(negedge clk);
    rst = 1'b0;
    apply(4'h8, 32'h7FFFFFFF, 32'h00000001);
    @(posedge clk); #1;
    cmp_reg("reg_add_ovf", 32'h80000000, 1'b1);
    @(negedge clk);
    apply(4'h1, 32'hF0F0F0F0, 32'hFF00FF00);
    @(posedge clk); #1;
    cmp_reg("reg_sticky_hold", 32'hF000F000, 1'b1);
    @(negedge clk);
    apply(4'h2, 32'h00000003, 32'h00000004);
    @(posedge clk); #1;
    cmp_reg("reg_sticky_hold2", 32'h00000007, 1'b1);
    // Async reset between edges clears both; combinational result unaffected.
    #1 rst = 1'b1;
    #1;
    cmp_reg("reg_async_rst", 32'h0, 1'b0);
    cmp_comb("comb_during_rst", 4'h2, 32'h3, 32'h4, ref_alu(4'h2, 32'h3, 32'h4));
    @(posedge clk); #1;
    cmp_reg("reg_rst_held", 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'hD, 32'h80000000, 32'h00000001);
    @(posedge clk); #1;
    cmp_reg("reg_slt_no_sticky", 32'h00000001, 1'b0);
    @(negedge clk);
    apply(4'hC, 32'h80000000, 32'h00000001);
    @(posedge clk); #1;
    cmp_reg("reg_sub_ovf", 32'h7FFFFFFF, 1'b1);

    // Cross: every code (including undefined ones) x corner pairs, then random pairs.
    for (int c = 0; c < 16; c++)
      for (int i = 0; i < 24; i++)
        for (int j = 0; j < 24; j++)
          check_model("corner_cross", 4'(c), corners[i], corners[j]);
    for (int c = 0; c < 11; c++)
      for (int r = 0; r < 25; r++) begin
        logic [31:0] ra, rb;
        ra = $urandom;
        rb = (r % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        check_model("random_cross", ctrls[c], ra, rb);
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
